// File: rtl/adder_seq_pkg.sv
// rtl/adder_seq_pkg.sv - shared FSM encoding, counter width and overflow helper for the adder sequencer
package adder_seq_pkg;

    // Encoding is exposed on the state output for LED debug, so values are fixed.
    typedef enum logic [1:0] {
        ST_WAIT_X  = 2'd0,
        ST_WAIT_Y  = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_SHOW    = 2'd3
    } state_t;

    // Holds PIPE_STAGES-1 for PIPE_STAGES up to 4.
    localparam int CNT_W = 2;

    // Two's-complement overflow: operands agree in sign but the result does not.
    function automatic logic signed_overflow(input logic x_msb,
                                             input logic yeff_msb,
                                             input logic sum_msb);
        return (x_msb == yeff_msb) && (sum_msb != x_msb);
    endfunction

endpackage

// File: rtl/adder_sequencer_pipelined_if.sv
// rtl/adder_sequencer_pipelined_if.sv - operand/control inputs and result outputs of the adder sequencer
// master: board wrapper side (drives data_in, carry_in, mode_sub, accumulate, enter)
// slave:  adder sequencer side (drives sum, carry_out, overflow, result_valid, busy, state)
interface adder_sequencer_pipelined_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             carry_in;
    logic             mode_sub;
    logic             accumulate;
    logic             enter;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             result_valid;
    logic             busy;
    logic [1:0]       state;

    modport master (
        output data_in, carry_in, mode_sub, accumulate, enter,
        input  sum, carry_out, overflow, result_valid, busy, state
    );

    modport slave (
        input  data_in, carry_in, mode_sub, accumulate, enter,
        output sum, carry_out, overflow, result_valid, busy, state
    );
endinterface

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchronizer plus rising-edge detector for a raw button level
// clock, reset : rising-edge clock, synchronous active-high reset
// in           : asynchronous button level, active-high
// pulse        : one-cycle pulse per press, three clock edges after the rising level
module edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic pulse
);
    logic sync1;
    logic sync2;
    logic prev;
    logic primed;
    logic armed;

    // A button held through reset must not look like a fresh press once reset
    // drops. The detector only arms after it has seen the synchronized level
    // low; primed skips the first post-reset cycle, when sync1 still holds its
    // reset value rather than a real sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            primed <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync1  <= in;
            sync2  <= sync1;
            prev   <= sync2;
            primed <= 1'b1;
            if (primed && !sync1) begin
                armed <= 1'b1;
            end
        end
    end

    assign pulse = sync2 & ~prev & armed;

endmodule

// File: rtl/unit_delay.sv
// rtl/unit_delay.sv - single enabled register stage with synchronous clear
// clock, reset : rising-edge clock, synchronous active-high reset
// en           : load enable
// d, q         : WIDTH-bit data in and registered data out
module unit_delay #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/adder_sequencer_pipelined.sv
// rtl/adder_sequencer_pipelined.sv - button-sequenced add/subtract unit with pipelined result and accumulate mode
// clock, reset : rising-edge clock, synchronous active-high reset
// bus (slave)  : data_in, carry_in, mode_sub, accumulate, enter in;
//                sum, carry_out, overflow, result_valid, busy, state out
module adder_sequencer_pipelined
    import adder_seq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PIPE_STAGES = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    adder_sequencer_pipelined_if.slave     bus
);
    localparam int             PW       = WIDTH + 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PIPE_STAGES - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               sub_q, sub_d;
    logic               cin_q, cin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               enter_pulse;

    logic [WIDTH-1:0]   y_eff;
    logic               cin_eff;
    logic [WIDTH:0]     full;
    logic               ovf;
    logic               pipe_en;
    // Stage 0 is the combinational adder result; stage PIPE_STAGES drives the outputs.
    logic [PIPE_STAGES:0][PW-1:0] pipe;
    logic [WIDTH-1:0]   sum_now;

    edge_sync u_enter_sync (
        .clock (clock),
        .reset (reset),
        .in    (bus.enter),
        .pulse (enter_pulse)
    );

    // Subtract is X + ~Y + 1; the carry input is overridden in that mode.
    assign y_eff   = sub_q ? ~y_q : y_q;
    assign cin_eff = sub_q | cin_q;
    assign full    = {1'b0, x_q} + {1'b0, y_eff} + {{WIDTH{1'b0}}, cin_eff};
    assign ovf     = signed_overflow(x_q[WIDTH-1], y_eff[WIDTH-1], full[WIDTH-1]);

    // Stages only advance while computing so the displayed result holds while
    // X/Y are being re-entered.
    assign pipe_en = (state_q == ST_COMPUTE);
    assign pipe[0] = {full[WIDTH], ovf, full[WIDTH-1:0]};

    for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_pipe
        unit_delay #(.WIDTH(PW)) u_stage (
            .clock (clock),
            .reset (reset),
            .en    (pipe_en),
            .d     (pipe[i]),
            .q     (pipe[i+1])
        );
    end

    assign sum_now          = pipe[PIPE_STAGES][WIDTH-1:0];
    assign bus.sum          = sum_now;
    assign bus.overflow     = pipe[PIPE_STAGES][WIDTH];
    assign bus.carry_out    = pipe[PIPE_STAGES][WIDTH+1];
    assign bus.result_valid = valid_q;
    assign bus.busy         = (state_q == ST_COMPUTE);
    assign bus.state        = state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_WAIT_X;
            x_q     <= '0;
            y_q     <= '0;
            sub_q   <= 1'b0;
            cin_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sub_q   <= sub_d;
            cin_q   <= cin_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sub_d   = sub_q;
        cin_d   = cin_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        case (state_q)
            ST_WAIT_X: begin
                if (enter_pulse) begin
                    x_d     = bus.data_in;
                    state_d = ST_WAIT_Y;
                end
            end
            ST_WAIT_Y: begin
                if (enter_pulse) begin
                    y_d     = bus.data_in;
                    sub_d   = bus.mode_sub;
                    cin_d   = bus.carry_in;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                // Presses here are dropped; the counter alone decides when the
                // last stage holds the new result.
                if (cnt_q == '0) begin
                    valid_d = 1'b1;
                    state_d = ST_SHOW;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SHOW: begin
                if (enter_pulse) begin
                    if (bus.accumulate) begin
                        x_d     = sum_now;
                        y_d     = bus.data_in;
                        sub_d   = bus.mode_sub;
                        cin_d   = bus.carry_in;
                        cnt_d   = CNT_LOAD;
                        state_d = ST_COMPUTE;
                    end else begin
                        x_d     = bus.data_in;
                        state_d = ST_WAIT_Y;
                    end
                end
            end
            default: state_d = ST_WAIT_X;
        endcase
    end

endmodule

// File: tb/tb_adder_sequencer_pipelined.sv
// tb/tb_adder_sequencer_pipelined.sv - directed self-checking bench for adder_sequencer_pipelined
module tb_adder_sequencer_pipelined;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       carry_in;
    logic       mode_sub;
    logic       accumulate;
    logic       enter;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clock = ~clock;

    adder_sequencer_pipelined_if #(.WIDTH(8)) bus1 ();
    adder_sequencer_pipelined_if #(.WIDTH(8)) bus3 ();

    assign bus1.data_in    = data_in;
    assign bus1.carry_in   = carry_in;
    assign bus1.mode_sub   = mode_sub;
    assign bus1.accumulate = accumulate;
    assign bus1.enter      = enter;
    assign bus3.data_in    = data_in;
    assign bus3.carry_in   = carry_in;
    assign bus3.mode_sub   = mode_sub;
    assign bus3.accumulate = accumulate;
    assign bus3.enter      = enter;

    adder_sequencer_pipelined #(.WIDTH(8), .PIPE_STAGES(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    adder_sequencer_pipelined #(.WIDTH(8), .PIPE_STAGES(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Enter high for exactly one sampled edge s; the pulse is acted on at s+2.
    task automatic tap(input logic [7:0] v);
        @(negedge clock);
        data_in = v;
        enter   = 1'b1;
        @(negedge clock);
        enter   = 1'b0;
    endtask

    // Returns at the negedge just after the accepting edge.
    task automatic press(input logic [7:0] v);
        tap(v);
        repeat (2) @(negedge clock);
    endtask

    task automatic do_op(input string name, input logic [7:0] x, input logic [7:0] y,
                         input logic cin, input logic sub,
                         input logic [7:0] esum, input logic ec, input logic eo);
        accumulate = 1'b0;
        press(x);
        check({name, " wait_y"}, 32'(bus1.state), 32'd1);
        carry_in = cin;
        mode_sub = sub;
        press(y);
        // Changing the mode after the latching edge must have no effect.
        carry_in = ~cin;
        mode_sub = ~sub;
        check({name, " rv early"}, 32'(bus1.result_valid), 32'd0);
        check({name, " st compute"}, 32'(bus1.state), 32'd2);
        check({name, " busy"}, 32'(bus1.busy), 32'd1);
        @(negedge clock);
        check({name, " rv"}, 32'(bus1.result_valid), 32'd1);
        check({name, " sum"}, 32'(bus1.sum), 32'(esum));
        check({name, " cout"}, 32'(bus1.carry_out), 32'(ec));
        check({name, " ovf"}, 32'(bus1.overflow), 32'(eo));
        check({name, " st show"}, 32'(bus1.state), 32'd3);
        @(negedge clock);
        check({name, " rv pulse"}, 32'(bus1.result_valid), 32'd0);
        repeat (3) @(negedge clock);
        check({name, " p3 sum"}, 32'(bus3.sum), 32'(esum));
        check({name, " p3 cout"}, 32'(bus3.carry_out), 32'(ec));
        check({name, " p3 ovf"}, 32'(bus3.overflow), 32'(eo));
        check({name, " p3 st"}, 32'(bus3.state), 32'd3);
    endtask

    initial begin
        int seen;
        reset      = 1'b1;
        enter      = 1'b1;
        data_in    = 8'h00;
        carry_in   = 1'b0;
        mode_sub   = 1'b0;
        accumulate = 1'b0;

        // Reset, with the button held throughout
        repeat (3) @(negedge clock);
        check("rst sum",   32'(bus1.sum), 32'd0);
        check("rst cout",  32'(bus1.carry_out), 32'd0);
        check("rst ovf",   32'(bus1.overflow), 32'd0);
        check("rst rv",    32'(bus1.result_valid), 32'd0);
        check("rst busy",  32'(bus1.busy), 32'd0);
        check("rst state", 32'(bus1.state), 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        check("held enter p1 state", 32'(bus1.state), 32'd0);
        check("held enter p3 state", 32'(bus3.state), 32'd0);
        enter = 1'b0;
        repeat (4) @(negedge clock);

        // Add, wrap/overflow, subtract
        do_op("add",   8'h3C, 8'h05, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0);
        do_op("ovf",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op("wrap",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op("sub",   8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);

        // Accumulate with PIPE_STAGES=3, extra press during COMPUTE
        do_op("acc base", 8'd10, 8'd20, 1'b0, 1'b0, 8'd30, 1'b0, 1'b0);
        accumulate = 1'b1;
        carry_in   = 1'b0;
        mode_sub   = 1'b0;
        tap(8'd5);
        @(negedge clock);
        enter = 1'b1;
        @(negedge clock);
        enter   = 1'b0;
        data_in = 8'd99;
        check("acc st compute", 32'(bus3.state), 32'd2);
        check("acc rv e0", 32'(bus3.result_valid), 32'd0);
        @(negedge clock);
        check("acc rv e1", 32'(bus3.result_valid), 32'd0);
        @(negedge clock);
        check("acc rv e2", 32'(bus3.result_valid), 32'd0);
        check("acc st e2", 32'(bus3.state), 32'd2);
        @(negedge clock);
        check("acc rv e3", 32'(bus3.result_valid), 32'd1);
        check("acc sum", 32'(bus3.sum), 32'd35);
        check("acc st show", 32'(bus3.state), 32'd3);
        repeat (3) @(negedge clock);
        check("acc sum hold", 32'(bus3.sum), 32'd35);
        check("acc st hold", 32'(bus3.state), 32'd3);
        check("acc rv low", 32'(bus3.result_valid), 32'd0);

        // Reset on the second COMPUTE cycle
        press(8'd1);
        check("flush st compute", 32'(bus3.state), 32'd2);
        check("flush busy", 32'(bus3.busy), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("flush state", 32'(bus3.state), 32'd0);
        check("flush sum", 32'(bus3.sum), 32'd0);
        check("flush rv", 32'(bus3.result_valid), 32'd0);
        check("flush busy low", 32'(bus3.busy), 32'd0);
        reset = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clock);
            if (bus3.result_valid) seen++;
        end
        check("flush no rv", 32'(seen), 32'd0);
        check("flush st after", 32'(bus3.state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_sequencer_pipelined.md
Name: adder_sequencer_pipelined

Overview:
- Parametrised successor to the board-level synchronized adder.
- Operands are entered one at a time from a shared data bus, qualified by an edge-detected enter button.
- A small FSM sequences capture of X and Y, then runs add/subtract through a configurable output pipeline, with an optional accumulate mode that chains results.
- Sits between the board switch/key wrapper and the LED/seven-segment display logic.

Parameters:
WIDTH, 8, operand and result width in bits (2..32)
PIPE_STAGES, 1, result register stages after the adder (1..4)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
data_in  in  WIDTH  operand value, sampled on accepted enter
carry_in  in  1  carry input for add mode
mode_sub  in  1  0 = X+Y+carry_in, 1 = X-Y (X + ~Y + 1)
accumulate  in  1  1 = after a result, the next operand is added to the previous sum
enter  in  1  raw asynchronous button level, active-high (inverted externally)
sum  out  WIDTH  registered result
carry_out  out  1  unsigned carry (in sub mode: 1 = no borrow)
overflow  out  1  signed two's-complement overflow
result_valid  out  1  one-cycle pulse when sum/flags update
busy  out  1  high in COMPUTE
state  out  2  current FSM state, for LED debug

Behaviour:
- Reset values:
  - sum = 0, carry_out = 0, overflow = 0, result_valid = 0, busy = 0.
  - State = WAIT_X; X, Y and all pipeline registers = 0.
  - Synchronizer flops = 0.
- Enter conditioning:
  - Two-flop synchronizer, then a previous-value flop; enter_pulse = sync2 & ~prev.
  - A rising edge of enter is acted on at the 3rd rising clock edge after it.
  - Holding enter high produces exactly one pulse; the button must be released before the next pulse.
- FSM states (2-bit encoding): WAIT_X = 0, WAIT_Y = 1, COMPUTE = 2, SHOW = 3.
  - WAIT_X: on enter_pulse, X <= data_in; go to WAIT_Y.
  - WAIT_Y: on enter_pulse, Y <= data_in, latch mode_sub and carry_in; go to COMPUTE.
  - COMPUTE:
    - Adder operates on the latched X and Y; the result enters the pipeline on the first COMPUTE cycle.
    - A down-counter runs PIPE_STAGES cycles; busy = 1 throughout.
    - enter_pulse is ignored and dropped.
    - When the counter reaches 0, sum/carry_out/overflow update and result_valid pulses for 1 cycle; go to SHOW.
    - Latency from the WAIT_Y enter_pulse edge to result_valid high is PIPE_STAGES cycles.
  - SHOW: outputs hold. On enter_pulse:
    - If accumulate = 1: X <= sum, Y <= data_in, latch mode/carry; go to COMPUTE.
    - If accumulate = 0: X <= data_in; go to WAIT_Y.
- Arithmetic:
  - The full WIDTH+1-bit result is computed; carry_out = bit WIDTH; sum = low WIDTH bits, wrapping modulo 2^WIDTH.
  - overflow = (X[msb] == Yeff[msb]) & (sum[msb] != X[msb]), where Yeff is Y or ~Y.
  - In sub mode carry_in is ignored; the carry in is forced to 1.
- Mode inputs are sampled only at the operand-latching edge; changes at other times have no effect.
- Reset has priority over everything in any state. Reset mid-COMPUTE flushes the pipeline; no result_valid is produced.
- enter_pulse and reset in the same cycle: reset wins and the pulse is lost.

Decomposition:
- Package adder_seq_pkg holds:
  - State constants ST_WAIT_X, ST_WAIT_Y, ST_COMPUTE, ST_SHOW (2-bit).
  - Function computing the overflow flag.
- Sub-module edge_sync contains the 2-flop synchronizer plus rising-edge detector, with clock/reset, in, pulse out. It is reused for other button inputs.
- Pipeline stages use the existing unit_delay-style register in a generate loop.

Test Plan:
1. Reset with WIDTH=8, PIPE_STAGES=1 -> all outputs 0, state = 0; enter held high during reset -> no pulse after reset until enter is released and pressed again.
2. Add: X=0x3C, Y=0x05, carry_in=1, mode_sub=0 -> sum=0x42, carry_out=0, overflow=0; result_valid is a single pulse 1 cycle after the Y-enter edge; state=3.
3. Wrap/overflow: X=0x7F + Y=0x01 -> sum=0x80, overflow=1, carry_out=0; X=0xFF + Y=0x01 -> sum=0x00, carry_out=1, overflow=0.
4. Subtract: X=0x05 - Y=0x07, carry_in=1 (must be ignored) -> sum=0xFE, carry_out=0, overflow=0.
5. Accumulate with PIPE_STAGES=3: 10+20 -> 30; in SHOW press enter with data_in=5 -> sum=35 after 3 cycles. Extra enter presses during COMPUTE are ignored and the result is unchanged.
6. Reset asserted on the 2nd COMPUTE cycle (PIPE_STAGES=3) -> no result_valid, sum=0, state=WAIT_X on the next cycle.
